// File: rtl/conv16_sched_pkg.sv
// Shared definitions for the 16-row 3-tap convolution sequencer:
// datapath widths, vector typedefs, the sequencer state encoding and
// the job-length legality helper.
package definition;

  // Element width of feature-map and filter values.
  localparam int width = 8;

  // Core geometry: 16 rows per column, 3 taps per filter column,
  // 8 partial sums per window.
  localparam int ROWS = 16;
  localparam int TAPS = 3;
  localparam int SUMS = 8;

  typedef logic [ROWS*width-1:0]   row_vec_t;
  typedef logic [TAPS*width-1:0]   filt_vec_t;
  typedef logic [SUMS*2*width-1:0] sum_vec_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } sched_state_t;

  // A job needs at least one full 3-column window and must fit in the
  // feature-map buffer.
  function automatic logic cols_legal(input int cols, input int cols_max);
    return (cols >= TAPS) && (cols <= cols_max);
  endfunction

endpackage

// File: rtl/conv16_sched_vld_pipe.sv
// conv16_vld_pipe: fixed-depth shift register that carries a
// {valid, column index} tag from the point a row vector is issued to
// the core until the matching sums come back. All stages reset to 0.
module conv16_vld_pipe #(
  parameter int DEPTH = 3,
  parameter int CW    = 6
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  input  logic [CW-1:0] in_col,
  output logic          out_valid,
  output logic [CW-1:0] out_col
);

  logic [DEPTH-1:0] vld_sr;
  logic [CW-1:0]    col_sr [DEPTH];

  // Shift the tag one stage per cycle; stage 0 takes the new tag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_sr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        col_sr[i] <= '0;
      end
    end else begin
      vld_sr[0] <= in_valid;
      col_sr[0] <= in_col;
      for (int i = 1; i < DEPTH; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        col_sr[i] <= col_sr[i-1];
      end
    end
  end

  assign out_valid = vld_sr[DEPTH-1];
  assign out_col   = col_sr[DEPTH-1];

endmodule

// File: rtl/conv16_sched.sv
// conv16_sched: job sequencer for the 16-row 3-tap convolution core.
// On start it reads the three filter columns and cfg_cols feature-map
// columns, streams them into the core, flushes the core pipeline and
// captures one 8-sum beat per complete 3-column window.
// Optional feature: define CONV16_SCHED_PERF_EN to get a saturating
// busy-cycle counter on perf_cyc; otherwise perf_cyc is tied to 0.
module conv16_sched
  import definition::*;
#(
  parameter int COLS_MAX = 64,
  parameter int AW       = $clog2(COLS_MAX),
  parameter int CORE_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [AW:0]              cfg_cols,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     w_rd,
  output logic [1:0]               w_addr,
  input  logic [TAPS*width-1:0]    w_data,
  output logic                     fm_rd,
  output logic [AW-1:0]            fm_addr,
  input  logic [ROWS*width-1:0]    fm_data,
  output logic                     conv_en,
  output logic [TAPS*width-1:0]    o_f,
  output logic [ROWS*width-1:0]    o_r,
  input  logic [SUMS*2*width-1:0]  i_sum,
  output logic                     out_valid,
  output logic [SUMS*2*width-1:0]  out_sum,
  output logic [AW-1:0]            out_col,
  output logic [31:0]              perf_cyc
);

  // The drain phase covers the memory read latency, the operand
  // register stage, the core latency and the sum capture register, so
  // the last window's beat lands before done.
  localparam int          DRAIN_LEN  = CORE_LAT + 3;
  localparam int          DW         = $clog2(DRAIN_LEN + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_LEN - 1);
  localparam logic [AW:0]   COLS_ONE   = (AW+1)'(1);

  sched_state_t  state;
  logic [AW:0]   cols_q;
  logic [DW-1:0] drain_cnt;

  logic          fm_rd_d;
  logic          w_rd_d;
  logic [AW-1:0] fm_addr_d;

  logic          cfg_ok;
  logic          last_tick;

  logic          tag_valid;
  logic [AW-1:0] tag_col;
  logic          pipe_valid;
  logic [AW-1:0] pipe_col;

  assign cfg_ok    = cols_legal(int'(cfg_cols), COLS_MAX);
  assign last_tick = ({1'b0, fm_addr} == (cols_q - COLS_ONE));

  // Job control: issues the memory reads, sequences drain and done,
  // and owns every registered control output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cols_q    <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      w_rd      <= 1'b0;
      w_addr    <= '0;
      fm_rd     <= 1'b0;
      fm_addr   <= '0;
      conv_en   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (fm_rd_d) begin
        conv_en <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (cfg_ok) begin
              state   <= STREAM;
              err     <= 1'b0;
              cols_q  <= cfg_cols;
              fm_rd   <= 1'b1;
              fm_addr <= '0;
              w_rd    <= 1'b1;
              w_addr  <= 2'd0;
            end else begin
              state <= DONE;
              err   <= 1'b1;
              done  <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (last_tick) begin
            state     <= DRAIN;
            drain_cnt <= '0;
            fm_rd     <= 1'b0;
            fm_addr   <= '0;
            w_rd      <= 1'b0;
            w_addr    <= 2'd0;
          end else begin
            fm_addr <= fm_addr + AW'(1);
            if (fm_addr < AW'(2)) begin
              w_rd   <= 1'b1;
              w_addr <= fm_addr[1:0] + 2'd1;
            end else begin
              w_rd   <= 1'b0;
              w_addr <= 2'd0;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state   <= DONE;
            done    <= 1'b1;
            conv_en <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Register returned memory data into the core operands; anything
  // not backed by a read this cycle is driven as zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fm_rd_d   <= 1'b0;
      w_rd_d    <= 1'b0;
      fm_addr_d <= '0;
      o_r       <= '0;
      o_f       <= '0;
    end else begin
      fm_rd_d   <= fm_rd;
      w_rd_d    <= w_rd;
      fm_addr_d <= fm_addr;
      o_r       <= fm_rd_d ? fm_data : '0;
      o_f       <= w_rd_d ? w_data : '0;
    end
  end

  // Rows 0 and 1 only prime the window, so the first tagged output is
  // row 2, reported as output column 0.
  assign tag_valid = fm_rd_d && (fm_addr_d >= AW'(2));
  assign tag_col   = fm_addr_d - AW'(2);

  conv16_vld_pipe #(
    .DEPTH (CORE_LAT + 1),
    .CW    (AW)
  ) u_vld_pipe (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (tag_valid),
    .in_col    (tag_col),
    .out_valid (pipe_valid),
    .out_col   (pipe_col)
  );

  // Capture the core sums when the tag for a complete window arrives.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_col   <= '0;
    end else begin
      out_valid <= pipe_valid;
      if (pipe_valid) begin
        out_sum <= i_sum;
        out_col <= pipe_col;
      end
    end
  end

`ifdef CONV16_SCHED_PERF_EN
  logic [31:0] perf_q;

  // Count busy cycles of the current job, saturating at all-ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_q <= '0;
    end else if ((state == IDLE) && start) begin
      perf_q <= '0;
    end else if (busy && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cyc = perf_q;
`else
  assign perf_cyc = '0;
`endif

endmodule

// File: tb/tb_conv16_sched.sv
// Directed self-checking bench for conv16_sched with behavioural
// weight/feature memories and a behavioural 2-cycle convolution core.
module tb_conv16_sched;
  import definition::*;

  localparam int COLS_MAX = 64;
  localparam int AW       = 6;
  localparam int CORE_LAT = 2;

  localparam int S_TAB  [3] = '{108, 153, 198};
  localparam int S7_TAB [3] = '{66, 93, 120};

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   cfg_cols = '0;
  logic          busy, done, err;
  logic          w_rd, fm_rd, conv_en, out_valid;
  logic [1:0]    w_addr;
  logic [AW-1:0] fm_addr, out_col;
  logic [23:0]   w_data = '0;
  logic [127:0]  fm_data = '0;
  logic [23:0]   o_f;
  logic [127:0]  o_r, i_sum, out_sum;
  logic [31:0]   perf_cyc;

  logic [127:0]  fm_mem [COLS_MAX];
  logic [23:0]   w_mem  [4];

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  int            rel, done_cyc, err_at_done, fm_cnt, w_cnt;
  int            conv_first, conv_last, busy_first, busy_last;
  logic [127:0]  r_at3;
  logic [23:0]   f_at3, f_at5, f_at6;
  logic [AW-1:0] addr_at3;
  int            beat_cyc [$];
  logic [AW-1:0] beat_col [$];
  logic [127:0]  beat_sum [$];

  // core model state
  logic [23:0]   fq0 = '0, fq1 = '0, fq2 = '0;
  int            fcnt = 0;
  logic [127:0]  h0 = '0, h1 = '0, st1 = '0, st2 = '0;

  conv16_sched #(
    .COLS_MAX (COLS_MAX),
    .AW       (AW),
    .CORE_LAT (CORE_LAT)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .cfg_cols  (cfg_cols),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .w_rd      (w_rd),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .fm_rd     (fm_rd),
    .fm_addr   (fm_addr),
    .fm_data   (fm_data),
    .conv_en   (conv_en),
    .o_f       (o_f),
    .o_r       (o_r),
    .i_sum     (i_sum),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_col   (out_col),
    .perf_cyc  (perf_cyc)
  );

  always #5 clk = ~clk;

  // Memories with a one-cycle registered read.
  always @(posedge clk) begin
    if (fm_rd) fm_data <= fm_mem[fm_addr];
    if (w_rd)  w_data  <= w_mem[w_addr];
  end

  function automatic logic [127:0] window_sum(input logic [127:0] ra, input logic [127:0] rb,
                                              input logic [127:0] rc, input logic [23:0] fa,
                                              input logic [23:0] fb, input logic [23:0] fc);
    logic [127:0] s;
    int acc;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      acc = 0;
      for (int t = 0; t < 3; t++) begin
        if (2*i + t < 16) begin
          acc = acc + int'(fa[8*t +: 8]) * int'(ra[8*(2*i+t) +: 8])
                    + int'(fb[8*t +: 8]) * int'(rb[8*(2*i+t) +: 8])
                    + int'(fc[8*t +: 8]) * int'(rc[8*(2*i+t) +: 8]);
        end
      end
      s[16*i +: 16] = acc[15:0];
    end
    return s;
  endfunction

  // Behavioural core: latches taps while enabled, sums the last three
  // rows against the three filter columns, two cycles of latency.
  always @(posedge clk) begin
    if (!conv_en) begin
      fcnt <= 0;
      h0   <= '0;
      h1   <= '0;
    end else begin
      case (fcnt)
        0: fq0 <= o_f;
        1: fq1 <= o_f;
        2: fq2 <= o_f;
        default: ;
      endcase
      if (fcnt < 3) fcnt <= fcnt + 1;
      h1 <= h0;
      h0 <= o_r;
    end
    st1 <= window_sum(h1, h0, o_r, fq0, fq1, (fcnt == 2) ? o_f : fq2);
    st2 <= st1;
  end
  assign i_sum = st2;

  function automatic logic [127:0] mk_sum(input int s, input int s7);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 7; i++) v[16*i +: 16] = 16'(s);
    v[127:112] = 16'(s7);
    return v;
  endfunction

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one job starting at the current negedge and logs every cycle.
  task automatic apply_stimulus(input int cols, input int pulse_at, input int abort_at);
    bit finished;
    finished = 1'b0;
    beat_cyc.delete();
    beat_col.delete();
    beat_sum.delete();
    done_cyc = -1; err_at_done = -1; fm_cnt = 0; w_cnt = 0;
    conv_first = -1; conv_last = -1; busy_first = -1; busy_last = -1;
    cfg_cols = (AW+1)'(cols);
    start = 1'b1;
    rel = 0;
    for (int n = 0; n < 300 && !finished; n++) begin
      @(negedge clk);
      rel++;
      start = (rel == pulse_at);
      if (abort_at > 0 && rel == abort_at) begin
        rstn = 1'b0;
        #1;
        check_vec("abort_ctrl", 128'({busy, done, err, w_rd, fm_rd, conv_en, out_valid,
                                     w_addr, fm_addr, out_col}), '0);
        check_vec("abort_data", o_r | 128'(o_f) | out_sum | 128'(perf_cyc), '0);
      end
      if (out_valid) begin
        beat_cyc.push_back(rel);
        beat_col.push_back(out_col);
        beat_sum.push_back(out_sum);
      end
      if (fm_rd) fm_cnt++;
      if (w_rd) w_cnt++;
      if (conv_en) begin
        if (conv_first < 0) conv_first = rel;
        conv_last = rel;
      end
      if (busy) begin
        if (busy_first < 0) busy_first = rel;
        busy_last = rel;
      end
      if (rel == 3) begin
        r_at3 = o_r;
        f_at3 = o_f;
        addr_at3 = fm_addr;
      end
      if (rel == 5) f_at5 = o_f;
      if (rel == 6) f_at6 = o_f;
      if (done && done_cyc < 0) begin
        done_cyc = rel;
        err_at_done = int'(err);
      end
      if (abort_at > 0) finished = (rel >= abort_at + 5);
      else              finished = (done_cyc >= 0);
    end
    check_int("job_finished", int'(finished), 1);
    if (abort_at > 0) rstn = 1'b1;
    @(negedge clk);
    rel++;
  endtask

  task automatic check_beats(input string tag, input int cols);
    check_int({tag, "_beats"}, beat_cyc.size(), cols - 2);
    for (int k = 2; k < cols && k < 5; k++) begin
      int i;
      i = k - 2;
      check_int({tag, "_col"}, (i < beat_col.size()) ? int'(beat_col[i]) : -1, i);
      check_int({tag, "_cyc"}, (i < beat_cyc.size()) ? beat_cyc[i] : -1, 4 + k + CORE_LAT);
      check_vec({tag, "_sum"}, (i < beat_sum.size()) ? beat_sum[i] : '1,
                mk_sum(S_TAB[i], S7_TAB[i]));
    end
  endtask

  initial begin
    for (int k = 0; k < COLS_MAX; k++) begin
      for (int e = 0; e < 16; e++) fm_mem[k][8*e +: 8] = 8'(k + 1);
    end
    for (int c = 0; c < 3; c++) begin
      for (int t = 0; t < 3; t++) w_mem[c][8*t +: 8] = 8'(3*c + t + 1);
    end
    w_mem[3] = '0;

    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_done", int'(done), 0);
    check_int("rst_err", int'(err), 0);
    check_int("rst_conv_en", int'(conv_en), 0);
    check_vec("rst_ctrl", 128'({fm_rd, w_rd, out_valid, fm_addr, w_addr, out_col}), '0);
    check_vec("rst_data", o_r | 128'(o_f) | out_sum | 128'(perf_cyc), '0);
    rstn = 1'b1;
    @(negedge clk);

    $display("[TB] job cols=5");
    apply_stimulus(5, 0, 0);
    check_beats("j5", 5);
    check_int("j5_done", done_cyc, 11);
    check_int("j5_err", err_at_done, 0);
    check_int("j5_conv_first", conv_first, 3);
    check_int("j5_conv_last", conv_last, 10);
    check_int("j5_busy_first", busy_first, 1);
    check_int("j5_busy_last", busy_last, 11);
    check_int("j5_fm_reads", fm_cnt, 5);
    check_int("j5_w_reads", w_cnt, 3);
    check_int("j5_fm_addr3", int'(addr_at3), 2);
    check_vec("j5_row0", r_at3, {16{8'h01}});
    check_vec("j5_tap1", 128'(f_at3), 128'(24'h030201));
    check_vec("j5_tap3", 128'(f_at5), 128'(24'h090807));
    check_vec("j5_tap_clr", 128'(f_at6), '0);
`ifdef CONV16_SCHED_PERF_EN
    check_int("j5_perf", int'(perf_cyc), 11);
`else
    check_int("j5_perf", int'(perf_cyc), 0);
`endif

    $display("[TB] illegal cols=2");
    apply_stimulus(2, 0, 0);
    check_int("c2_done", done_cyc, 1);
    check_int("c2_err", err_at_done, 1);
    check_int("c2_fm_reads", fm_cnt + w_cnt, 0);
    check_int("c2_conv_en", conv_first, -1);
    check_int("c2_beats", beat_cyc.size(), 0);
    check_int("c2_err_sticky", int'(err), 1);

    $display("[TB] illegal cols=65");
    apply_stimulus(COLS_MAX + 1, 0, 0);
    check_int("c65_done", done_cyc, 1);
    check_int("c65_err", err_at_done, 1);
    check_int("c65_fm_reads", fm_cnt, 0);
    check_int("c65_conv_en", conv_first, -1);

    $display("[TB] back-to-back cols=4 then cols=3");
    apply_stimulus(4, 0, 0);
    check_beats("b4", 4);
    check_int("b4_done", done_cyc, 10);
    check_int("b4_err", err_at_done, 0);
    apply_stimulus(3, 0, 0);
    check_beats("b3", 3);
    check_int("b3_done", done_cyc, 9);
    check_int("b3_err", err_at_done, 0);

    $display("[TB] start pulsed mid-job");
    apply_stimulus(5, 4, 0);
    check_beats("mid", 5);
    check_int("mid_done", done_cyc, 11);

    $display("[TB] reset abort at cycle 6 of cols=8");
    apply_stimulus(8, 0, 6);
    check_int("abort_done", done_cyc, -1);
    check_int("abort_beats", beat_cyc.size(), 0);

    $display("[TB] job after abort cols=5");
    apply_stimulus(5, 0, 0);
    check_beats("post", 5);
    check_int("post_done", done_cyc, 11);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
